// File: rtl/need_pkg.sv
// need_pkg: shared level widths, bounds, mode encoding and saturating step helper.
package need_pkg;
  localparam int LVL_W = 3;
  localparam logic [LVL_W-1:0] LVL_MAX = 3'd5;
  localparam logic [LVL_W-1:0] LVL_MIN = 3'd0;
  typedef enum logic {MODE_AWAKE = 1'b0, MODE_SLEEP = 1'b1} mode_e;
  typedef logic [LVL_W-1:0] lvl_t;
  function automatic lvl_t lvl_step(lvl_t l, logic up, logic dn);
    return up ? ((l == LVL_MAX) ? l : l + 1'b1) :
           dn ? ((l == LVL_MIN) ? l : l - 1'b1) : l;
  endfunction
endpackage

// File: rtl/need_decay_timer.sv
// need_decay_timer: counts ticks and pulses decay every DECAY ticks; restart/hold clear it and suppress the pulse.
module need_decay_timer #(
  parameter int DECAY = 10
) (
  input  logic clk,
  input  logic reset,
  input  logic tick,
  input  logic restart,
  input  logic hold,
  output logic decay
);
  localparam int CW = (DECAY > 1) ? $clog2(DECAY) : 1;
  logic [CW-1:0] cnt_q;
  logic wrap;
  assign wrap  = tick && (cnt_q == CW'(DECAY - 1));
  assign decay = wrap && !restart && !hold;
  always_ff @(posedge clk) begin
    if (reset || restart || hold || wrap) cnt_q <= '0;
    else if (tick) cnt_q <= cnt_q + 1'b1;
  end
endmodule

// File: rtl/need_level_ctrl.sv
// need_level_ctrl: four decaying/recovering pet need levels plus AWAKE/SLEEPING mode FSM.
// Optional NEED_FAST_DECAY_EN adds fast_en, which forces a tick every cycle.
module need_level_ctrl
  import need_pkg::*;
#(
  parameter int TICK_DIV = 50_000_000,
  parameter int DECAY_H  = 10,
  parameter int DECAY_S  = 20,
  parameter int DECAY_F  = 8,
  parameter int DECAY_E  = 30
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             btn_feed,
  input  logic             btn_sleep,
  input  logic             btn_play,
  input  logic             btn_heal,
`ifdef NEED_FAST_DECAY_EN
  input  logic             fast_en,
`endif
  output logic [LVL_W-1:0] NH,
  output logic [LVL_W-1:0] NS,
  output logic [LVL_W-1:0] NF,
  output logic [LVL_W-1:0] NE,
  output logic             sleeping,
  output logic             tick
);
  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  logic [PW-1:0] pre_q;
  logic tick_q, fast, pre_top, awake;
  logic feed, play, heal, dec_h, dec_s, dec_f, dec_e;
  lvl_t nh_q, ns_q, nf_q, ne_q, nh_d, ns_d, nf_d, ne_d;
  mode_e mode_q, mode_d;
`ifdef NEED_FAST_DECAY_EN
  assign fast = fast_en;
`else
  assign fast = 1'b0;
`endif
  assign pre_top = pre_q == PW'(TICK_DIV - 1);
  always_ff @(posedge clk) begin
    if (reset) begin
      pre_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      pre_q  <= (fast || pre_top) ? '0 : pre_q + 1'b1;
      tick_q <= fast || pre_top;
    end
  end
  // Actions are ignored while sleeping so they neither raise levels nor restart timers.
  assign awake = mode_q == MODE_AWAKE;
  assign feed  = btn_feed && awake;
  assign play  = btn_play && awake;
  assign heal  = btn_heal && awake;
  need_decay_timer #(.DECAY(DECAY_H)) u_h (.clk(clk), .reset(reset), .tick(tick_q), .restart(feed), .hold(1'b0), .decay(dec_h));
  need_decay_timer #(.DECAY(DECAY_S)) u_s (.clk(clk), .reset(reset), .tick(tick_q), .restart(1'b0), .hold(!awake), .decay(dec_s));
  need_decay_timer #(.DECAY(DECAY_F)) u_f (.clk(clk), .reset(reset), .tick(tick_q), .restart(play), .hold(1'b0), .decay(dec_f));
  need_decay_timer #(.DECAY(DECAY_E)) u_e (.clk(clk), .reset(reset), .tick(tick_q), .restart(heal), .hold(1'b0), .decay(dec_e));
  always_comb begin
    nh_d   = lvl_step(nh_q, feed, dec_h);
    nf_d   = lvl_step(nf_q, play, dec_f);
    ne_d   = lvl_step(ne_q, heal, dec_e);
    ns_d   = awake ? lvl_step(ns_q, 1'b0, dec_s) : lvl_step(ns_q, tick_q, 1'b0);
    mode_d = awake ? (btn_sleep ? MODE_SLEEP : MODE_AWAKE)
                   : ((btn_sleep || ns_d == LVL_MAX) ? MODE_AWAKE : MODE_SLEEP);
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      nh_q   <= LVL_MAX;
      ns_q   <= LVL_MAX;
      nf_q   <= LVL_MAX;
      ne_q   <= LVL_MAX;
      mode_q <= MODE_AWAKE;
    end else begin
      nh_q   <= nh_d;
      ns_q   <= ns_d;
      nf_q   <= nf_d;
      ne_q   <= ne_d;
      mode_q <= mode_d;
    end
  end
  assign NH       = nh_q;
  assign NS       = ns_q;
  assign NF       = nf_q;
  assign NE       = ne_q;
  assign sleeping = mode_q == MODE_SLEEP;
  assign tick     = tick_q;
endmodule
